// File: rtl/multiword_add_sequencer.sv
// rtl/multiword_add_sequencer.sv - multi-precision add/subtract sequencer
// Streams WORDS operand pairs LS-first through one WIDTH-bit slice with a registered carry.
module multiword_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             addSub,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] out,
  output logic             outLast,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  logic             r_op;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_cout;
  logic             r_overflow;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;

  // A new word may enter when the single output slot is empty or draining this cycle.
  assign w_in_ready = (r_state == S_RUN) & (~r_out_valid | outReady);
  assign w_accept   = inValid & w_in_ready;
  assign w_last     = (r_count == LAST);
  assign w_b_eff    = b ^ {WIDTH{r_op}};
  assign w_sum      = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_carry};
  assign w_ovf      = (a[WIDTH-1] == w_b_eff[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_op    <= addSub;
            r_carry <= addSub;
            r_count <= '0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_out       <= w_sum[WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_carry     <= w_sum[WIDTH];
            r_count     <= r_count + 1'b1;
            r_out_last  <= w_last;
            // Subtract reports borrow, the inverse of the final carry out.
            r_cout      <= w_last & (w_sum[WIDTH] ^ r_op);
            r_overflow  <= w_last & w_ovf;
            if (w_last) r_state <= S_DRAIN;
          end else if (outReady) begin
            r_out_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (outReady) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inReady  = w_in_ready;
  assign outValid = r_out_valid;
  assign out      = r_out;
  assign outLast  = r_out_last;
  assign cout     = r_cout;
  assign overflow = r_overflow;
  assign busy     = (r_state == S_RUN) | (r_state == S_DRAIN);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb/tb_multiword_add_sequencer.sv - scoreboard bench for multiword_add_sequencer
module tb_multiword_add_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       addSub;
  logic       inValid;
  logic       inReady;
  logic [7:0] a;
  logic [7:0] b;
  logic       outValid;
  logic       outReady;
  logic [7:0] out;
  logic       outLast;
  logic       cout;
  logic       overflow;
  logic       busy;

  typedef struct packed {
    logic [7:0] o;
    logic       l;
    logic       c;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  multiword_add_sequencer #(.WIDTH(8), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .addSub(addSub),
    .inValid(inValid), .inReady(inReady), .a(a), .b(b),
    .outValid(outValid), .outReady(outReady), .out(out), .outLast(outLast),
    .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && outValid === 1'b1 && outReady === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got out=%h last=%b with no expected word", out, outLast);
      end else begin
        e = q.pop_front();
        chk("result{out,last,cout,ovf}", 32'({out, outLast, cout, overflow}), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv);
    int g;
    g = 0;
    inValid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    while (inReady !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("send_timeout", 32'(g < 100), 32'd1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((q.size() != 0 || busy === 1'b1) && g < 200) begin
      cyc();
      g++;
    end
    chk("drain_timeout", 32'(g < 200), 32'd1);
    chk("outvalid_idle", 32'(outValid), 32'd0);
  endtask

  // mode 1: inValid with junk data alongside start; mode 2: stray start while in RUN.
  task automatic run_op(input logic sub, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] r, input logic ec, input logic ev,
                        input int gap, input int mode);
    exp_t e;
    start  = 1'b1;
    addSub = sub;
    if (mode == 1) begin
      inValid = 1'b1;
      a = 8'hAA;
      b = 8'h55;
    end
    @(negedge clk);
    if (mode == 1) chk("inready_at_start", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    start   = 1'b0;
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.o = r[8*i +: 8];
      e.l = (i == 3);
      e.c = (i == 3) ? ec : 1'b0;
      e.v = (i == 3) ? ev : 1'b0;
      q.push_back(e);
      if (mode == 2 && i == 1) begin
        start  = 1'b1;
        addSub = ~sub;
      end
      send(av[8*i +: 8], bv[8*i +: 8]);
      start = 1'b0;
      repeat (gap) cyc();
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int g;
    reset = 1'b1; start = 1'b0; addSub = 1'b0; inValid = 1'b0;
    outReady = 1'b1; a = 8'h00; b = 8'h00;
    cyc();
    chk("reset_outvalid", 32'(outValid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_flags", 32'({outLast, cout, overflow, busy, inReady}), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    run_op(1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 0, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 0, 0);
    run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 0, 0);
    run_op(1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 0);
    run_op(1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 0, 0);

    outReady = 1'b0;
    fork
      run_op(1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 0, 0);
      begin
        g = 0;
        @(negedge clk);
        while (outValid !== 1'b1 && g < 100) begin
          @(negedge clk);
          g++;
        end
        chk("stall_wait_timeout", 32'(g < 100), 32'd1);
        for (int k = 0; k < 3; k++) begin
          chk("stall_outvalid", 32'(outValid), 32'd1);
          chk("stall_out", 32'(out), 32'h00);
          chk("stall_inready", 32'(inReady), 32'd0);
          if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join

    run_op(1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 0, 1);
    run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 0, 2);
    run_op(1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 2, 0);

    start = 1'b1;
    addSub = 1'b0;
    cyc();
    start = 1'b0;
    e.o = 8'h00; e.l = 1'b0; e.c = 1'b0; e.v = 1'b0;
    q.push_back(e);
    send(8'hFF, 8'h01);
    send(8'h00, 8'h00);
    reset = 1'b1;
    #1;
    chk("midreset_outvalid", 32'(outValid), 32'd0);
    chk("midreset_out", 32'(out), 32'd0);
    chk("midreset_flags", 32'({outLast, cout, overflow, busy, inReady}), 32'd0);
    chk("midreset_queue", 32'(q.size()), 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    run_op(1'b0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
Sequential multi-precision add/subtract controller that sits directly upstream of the carry look-ahead adder datapath. It accepts WORDS operand word-pairs one per handshake, least-significant word first. It applies each pair to a WIDTH-bit adder slice with the carry/borrow registered from the previous word, and streams registered result words downstream. This gives WIDTH*WORDS-bit arithmetic from a single narrow adder.

Parameters:
WIDTH, 8, width of one operand/result word
WORDS, 4, number of words per operation (>=2); total operand width WIDTH*WORDS

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin an operation; sampled only in IDLE
addSub  input  1  0 = add, 1 = subtract; latched with start
inValid  input  1  operand word pair valid
inReady  output  1  sequencer can accept an operand word pair this cycle
a  input  WIDTH  augend/minuend word
b  input  WIDTH  addend/subtrahend word
outValid  output  1  result word valid
outReady  input  1  downstream accepts result word
out  output  WIDTH  sum/difference word
outLast  output  1  high with the most-significant result word
cout  output  1  final carry (add) or borrow (sub); valid only when outValid & outLast
overflow  output  1  signed two's-complement overflow of the full-width result; valid only when outValid & outLast
busy  output  1  high in RUN and DRAIN

Behaviour:
- Reset (async, active-high): state=IDLE; carry reg=0; word count=0; op reg=0; outValid=0, outLast=0, out=0, cout=0, overflow=0, busy=0, inReady=0. Takes effect immediately, including mid-operation. Partial results are discarded, not flushed.
- States:
  - IDLE: inReady=0. start=1 moves to RUN, latches addSub into op reg, sets carry reg=addSub, clears count.
  - RUN: accepts words. Moves to DRAIN on acceptance of word WORDS-1.
  - DRAIN: holds the last result until accepted. outValid&outReady moves to IDLE.
- start outside IDLE is ignored. start and inValid in the same IDLE cycle: only start acts; no word is accepted.
- inReady = (state==RUN) & (~outValid | outReady). Single output register; full throughput when outReady is held high.
- Word accepted when inValid & inReady. On acceptance (registered, 1-cycle latency):
  - bEff = b XOR {WIDTH{op}}
  - {c, s} = a + bEff + carry (WIDTH+1-bit result)
  - out<=s, outValid<=1, carry<=c, count<=count+1
  - outLast<=1 iff count==WORDS-1
- Final word only:
  - cout<=c for add, cout<=~c for sub (borrow)
  - overflow<=(a[MSB]==bEff[MSB]) & (s[MSB]!=a[MSB])
- Non-final words: cout and overflow are driven 0.
- Output hold: while outValid & ~outReady, out, outLast, cout and overflow are stable and no new word is accepted.
- outValid falls the cycle after acceptance unless a new word is accepted in that same cycle (simultaneous in/out handshake is legal in RUN).
- busy=1 in RUN and DRAIN. Next start is accepted on the cycle after return to IDLE. Minimum op period is WORDS+2 cycles.
- count is wide enough for WORDS-1. No wrap beyond the final word: RUN exits at count WORDS-1.

Test Plan (WIDTH=8, WORDS=4, words listed LS first):
1. Add 0x000000FF+0x00000001: a=FF,00,00,00; b=01,00,00,00; outReady=1 -> out=00,01,00,00; outLast only on 4th word; cout=0; overflow=0.
2. Carry ripple 0xFFFFFFFF+0x00000001 -> out=00,00,00,00; cout=1; overflow=0. Then 0x7FFFFFFF+0x00000001 -> out=00,00,00,80; cout=0; overflow=1.
3. Subtract 0x00000000-0x00000001 (addSub=1) -> out=FF,FF,FF,FF; cout(borrow)=1; overflow=0. Then 0x80000000-0x00000001 -> out=FF,FF,FF,7F; cout=0; overflow=1.
4. Backpressure: run test 1 with outReady=0 for 3 cycles after the first result -> out=00 and outValid held stable, inReady=0 during the stall, no word lost or duplicated, final sequence unchanged.
5. Handshake corner cases:
   - start asserted in RUN -> ignored.
   - start with inValid in the same IDLE cycle -> word not consumed.
   - inValid gaps between words -> results unchanged.
6. Reset mid-op: assert reset after the 2nd word is accepted -> outputs zero in the same cycle; state IDLE. A fresh add 0x00000002+0x00000003 then yields 05,00,00,00, cout=0, with no stale carry.
